mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported main memory between the instruction-fetch path and the data
//  cacheline. Grants one requester at a time, holds the memory interface stable for a
//  fixed access latency, then returns read data with a one-cycle valid pulse. Data side
//  has priority; a starvation guard bounds how long instruction fetch can be blocked.
// PARAMETERS
//  WIDTH         32  address/data width
//  MEM_LATENCY   2   cycles a memory access occupies (>=1)
//  STARVE_LIMIT  3   consecutive data grants with fetch pending before fetch is forced
// PORTS
//  clk_i               in   1      clock, all state on rising edge
//  rst_ni              in   1      asynchronous reset, active low
//  if_req_i            in   1      fetch request; addr held stable until if_gnt_o
//  if_addr_i           in   WIDTH  fetch word address
//  if_gnt_o            out  1      fetch request accepted this cycle
//  if_rvalid_o         out  1      fetch data valid (1-cycle pulse)
//  if_rdata_o          out  WIDTH  fetch data
//  dc_req_i            in   1      data request; fields held stable until dc_gnt_o
//  dc_we_i             in   1      1 = store, 0 = load
//  dc_byte_op_i        in   1      byte store
//  dc_addr_i           in   WIDTH  data address
//  dc_wdata_i          in   WIDTH  store data
//  dc_gnt_o            out  1      data request accepted this cycle
//  dc_rvalid_o         out  1      load data valid / store ack (1-cycle pulse)
//  dc_rdata_o          out  WIDTH  load data (0 for stores)
//  mem_address_o       out  WIDTH  to memory
//  mem_write_data_o    out  WIDTH  to memory
//  mem_write_enable_o  out  1      to memory
//  mem_byte_op_o       out  1      to memory
//  mem_incoming_data_i in   WIDTH  from memory
//  busy_o              out  1      state != IDLE
// BEHAVIOUR
//  Reset (async, rst_ni=0): state IDLE, all outputs 0, starve count 0; mem_write_enable_o
//   drops immediately even mid-access; in-flight transaction discarded, no rvalid.
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE: if any req, winner chosen combinationally, its gnt_o=1 this cycle; at the edge
//   owner, addr, wdata, we, byte_op latched; ACCESS count loaded MEM_LATENCY-1. No req: stay.
//  Winner: dc if dc_req_i, unless if_req_i && starve==STARVE_LIMIT -> if. Otherwise if.
//  Starve count: +1 (saturating) on a dc grant while if_req_i=1; cleared on if grant;
//   unchanged otherwise. Width $clog2(STARVE_LIMIT+1).
//  ACCESS: mem_* driven from latched regs for exactly MEM_LATENCY cycles; fetch owner
//   forces mem_write_enable_o=0, mem_byte_op_o=0. Count decrements; at count==0 the edge
//   captures mem_incoming_data_i (loads/fetch) or 0 (stores) and moves to DONE.
//  DONE: owner's rvalid_o=1 for one cycle with rdata; mem_write_enable_o=0; -> IDLE.
//   rdata_o holds last value until next capture.
//  Outside ACCESS: mem_write_enable_o=0, mem_byte_op_o=0, mem_address_o/mem_write_data_o hold.
//  Latency: grant cycle T -> rvalid at T+MEM_LATENCY+1; throughput one op per MEM_LATENCY+2.
//  Req changes/drops during ACCESS/DONE ignored; gnt_o only in IDLE, never both gnts.
//  Req dropped before gnt: no grant, no state change. Back-to-back req from same side
//   after rvalid is arbitrated normally in the following IDLE cycle.
// STRUCTURE
//  Package mem_arb_pkg: state_t enum {IDLE, ACCESS, DONE}, owner_t enum {OWN_IF, OWN_DC}.
//  Sub-module mem_arb_prio: winner select + starvation counter (comb select, registered
//   count); top holds FSM, latency counter, request/response registers.
// TESTING
//  Lone fetch addr 0x40, mem returns 0xDEADBEEF -> if_gnt T0, mem_address_o=0x40 T1..T2,
//   if_rvalid T3 with 0xDEADBEEF; dc outputs silent.
//  Simultaneous if/dc load -> dc_gnt first, if_gnt in next IDLE; starve count 1 then 0.
//  dc_req held high with if_req high, STARVE_LIMIT=3 -> grants dc,dc,dc,if,dc...
//  dc store byte addr 0x13 data 0xAB -> mem_write_enable_o=1, mem_byte_op_o=1 for exactly
//   MEM_LATENCY cycles, dc_rvalid with rdata=0, write enable 0 in DONE.
//  rst_ni low during ACCESS of a store -> mem_write_enable_o 0 same cycle, no rvalid,
//   IDLE after release, next request served normally.
//  Requester drops req during ACCESS / changes addr -> latched addr kept, rvalid still issued.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction-fetch / data-cache memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DC
  } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between fetch and data requests, with a saturating starvation counter
// that forces a fetch grant after STARVE_LIMIT consecutive data grants.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic arb_en_i,
  input  logic if_req_i,
  input  logic dc_req_i,
  output logic if_win_o,
  output logic dc_win_o
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] Limit = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_starve;
  logic          w_force_if;

  always_comb begin
    w_force_if = if_req_i && (r_starve == Limit);
    dc_win_o   = arb_en_i && dc_req_i && !w_force_if;
    if_win_o   = arb_en_i && if_req_i && !dc_win_o;
  end

  // Only data grants that actually kept fetch waiting count towards starvation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_starve <= '0;
    end else if (if_win_o) begin
      r_starve <= '0;
    end else if (dc_win_o && if_req_i && (r_starve != Limit)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported memory between instruction fetch and the data cacheline:
// grant, hold the access for MEM_LATENCY cycles, then pulse rvalid with the read data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             if_req_i,
  input  logic [WIDTH-1:0] if_addr_i,
  output logic             if_gnt_o,
  output logic             if_rvalid_o,
  output logic [WIDTH-1:0] if_rdata_o,
  input  logic             dc_req_i,
  input  logic             dc_we_i,
  input  logic             dc_byte_op_i,
  input  logic [WIDTH-1:0] dc_addr_i,
  input  logic [WIDTH-1:0] dc_wdata_i,
  output logic             dc_gnt_o,
  output logic             dc_rvalid_o,
  output logic [WIDTH-1:0] dc_rdata_o,
  output logic [WIDTH-1:0] mem_address_o,
  output logic [WIDTH-1:0] mem_write_data_o,
  output logic             mem_write_enable_o,
  output logic             mem_byte_op_o,
  input  logic [WIDTH-1:0] mem_incoming_data_i,
  output logic             busy_o
);

  localparam int unsigned LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LW-1:0] CntLoad = LW'(MEM_LATENCY - 1);

  state_t           r_state;
  owner_t           r_owner;
  logic [LW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic             r_we;
  logic             r_byte;
  logic [WIDTH-1:0] r_if_rdata;
  logic [WIDTH-1:0] r_dc_rdata;

  logic             w_if_win;
  logic             w_dc_win;
  logic             w_access;
  logic [WIDTH-1:0] w_cap_data;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .arb_en_i(r_state == IDLE),
    .if_req_i(if_req_i),
    .dc_req_i(dc_req_i),
    .if_win_o(w_if_win),
    .dc_win_o(w_dc_win)
  );

  assign w_access   = (r_state == ACCESS);
  assign w_cap_data = r_we ? '0 : mem_incoming_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_owner    <= OWN_IF;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_byte     <= 1'b0;
      r_if_rdata <= '0;
      r_dc_rdata <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_dc_win) begin
            r_state <= ACCESS;
            r_cnt   <= CntLoad;
            r_owner <= OWN_DC;
            r_addr  <= dc_addr_i;
            r_wdata <= dc_wdata_i;
            r_we    <= dc_we_i;
            r_byte  <= dc_byte_op_i;
          end else if (w_if_win) begin
            // Fetch leaves the write-data bus at its last value.
            r_state <= ACCESS;
            r_cnt   <= CntLoad;
            r_owner <= OWN_IF;
            r_addr  <= if_addr_i;
            r_we    <= 1'b0;
            r_byte  <= 1'b0;
          end
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            r_state <= DONE;
            if (r_owner == OWN_DC) begin
              r_dc_rdata <= w_cap_data;
            end else begin
              r_if_rdata <= w_cap_data;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_gnt_o           = w_if_win;
  assign dc_gnt_o           = w_dc_win;
  assign if_rvalid_o        = (r_state == DONE) && (r_owner == OWN_IF);
  assign dc_rvalid_o        = (r_state == DONE) && (r_owner == OWN_DC);
  assign if_rdata_o         = r_if_rdata;
  assign dc_rdata_o         = r_dc_rdata;
  assign mem_address_o      = r_addr;
  assign mem_write_data_o   = r_wdata;
  assign mem_write_enable_o = w_access && (r_owner == OWN_DC) && r_we;
  assign mem_byte_op_o      = w_access && (r_owner == OWN_DC) && r_byte;
  assign busy_o             = (r_state != IDLE);

endmodule
